tx_scrambler: RTL and testbench

TX_SCRAMBLER -- requirements
Module: tx_scrambler

---
 rtl/tx_scrambler.sv | 127 ++++++++++++
 tb/tb_tx_scrambler.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/tx_scrambler.sv
// 802.11-style x^7+x^4+1 TX scrambler with SERVICE/PSDU/tail/pad framing.
// Define TX_SCR_TAIL_ZERO_EN to force the 6 tail output bits to zero.
module tx_scrambler (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iStart,
  input  logic [6:0]  iSeed,
  input  logic [11:0] iLen,
  input  logic [8:0]  iPad,
  input  logic        iValid,
  input  logic        iData,
  output logic        oValid,
  output logic        oData,
  output logic        oBusy,
  output logic        oDone
);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    TAIL,
    PAD
  } state_e;

  localparam logic [6:0] SeedSub = 7'b1011101;

  state_e      state_q, state_d;
  logic [6:0]  lfsr_q, lfsr_d;
  logic [15:0] cnt_q, cnt_d;
  logic [11:0] len_q, len_d;
  logic [8:0]  pad_q, pad_d;
  logic        val_q, val_d;
  logic        dat_q, dat_d;
  logic        done_q, done_d;

  logic        acc;
  logic        fb;
  logic [15:0] data_end;
  logic [15:0] tail_end;
  logic [15:0] pad_end;

  // Bit indices of the last DATA, TAIL and PAD bit of the frame.
  assign data_end = 16'd15 + {1'b0, len_q, 3'b000};
  assign tail_end = data_end + 16'd6;
  assign pad_end  = tail_end + {7'd0, pad_q};

  assign acc = iValid && (state_q != IDLE);
  assign fb  = lfsr_q[6] ^ lfsr_q[3];

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    pad_d   = pad_q;
    val_d   = acc;
    done_d  = 1'b0;
`ifdef TX_SCR_TAIL_ZERO_EN
    dat_d   = acc && (state_q != TAIL) && (iData ^ fb);
`else
    dat_d   = acc && (iData ^ fb);
`endif
    if (acc) begin
      lfsr_d = {lfsr_q[5:0], fb};
      cnt_d  = cnt_q + 16'd1;
    end
    unique case (state_q)
      IDLE: begin
        if (iStart) begin
          state_d = DATA;
          lfsr_d  = (iSeed == 7'd0) ? SeedSub : iSeed;
          len_d   = iLen;
          pad_d   = iPad;
          cnt_d   = 16'd0;
        end
      end
      DATA: begin
        if (acc && cnt_q == data_end) state_d = TAIL;
      end
      TAIL: begin
        if (acc && cnt_q == tail_end) begin
          if (pad_q != 9'd0) begin
            state_d = PAD;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      PAD: begin
        if (acc && cnt_q == pad_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= IDLE;
      lfsr_q  <= 7'd0;
      cnt_q   <= 16'd0;
      len_q   <= 12'd0;
      pad_q   <= 9'd0;
      val_q   <= 1'b0;
      dat_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      pad_q   <= pad_d;
      val_q   <= val_d;
      dat_q   <= dat_d;
      done_q  <= done_d;
    end
  end

  assign oValid = val_q;
  assign oData  = dat_q;
  assign oDone  = done_q;
  assign oBusy  = (state_q != IDLE);

endmodule

// File: tb/tb_tx_scrambler.sv
// Scoreboard bench for tx_scrambler: random frames against a reference
// LFSR model, plus seed, reset-abort, mid-frame start and loopback cases.
module tb_tx_scrambler;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iStart;
  logic [6:0]  iSeed;
  logic [11:0] iLen;
  logic [8:0]  iPad;
  logic        iValid;
  logic        iData;
  logic        oValid;
  logic        oData;
  logic        oBusy;
  logic        oDone;

  tx_scrambler dut (
    .iClk(iClk), .iRst(iRst), .iStart(iStart), .iSeed(iSeed),
    .iLen(iLen), .iPad(iPad), .iValid(iValid), .iData(iData),
    .oValid(oValid), .oData(oData), .oBusy(oBusy), .oDone(oDone)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    bit d;
    bit done;
    int cyc;
  } exp_t;

  exp_t sbq[$];
  bit   got_q[$];
  bit   sent_q[$];
  bit   fixed_d[$];
  bit   out_a[$];
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;
  bit   tz = 1'b0;

  always @(posedge iClk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                  name, act, exp, cyc);
  endtask

  // Monitor: pops one expectation per presented output bit.
  always @(negedge iClk) begin
    exp_t e;
    if (oValid) begin
      if (sbq.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        e = sbq.pop_front();
        check("data", int'(oData), int'(e.d));
        check("done", int'(oDone), int'(e.done));
        check("latency", cyc, e.cyc);
      end
      if (oDone) check("busy_at_done", int'(oBusy), 0);
      got_q.push_back(oData);
    end else if (oDone) begin
      check("done_without_valid", 1, 0);
    end
  end

  // dmode: 0 random, 1 all zero, 2 from fixed_d. abort_at<0: no abort.
  task automatic run_frame(input bit [6:0] seed, input int len,
                           input int pad, input int dmode, input bit gaps,
                           input int abort_at, input bit mid_start);
    int s[1:7];
    int n;
    int fb;
    bit d;
    bit o;
    bit [6:0] eff;
    n = 16 + 8 * len + 6 + pad;
    eff = (seed == 7'd0) ? 7'b1011101 : seed;
    for (int k = 1; k <= 7; k++) s[k] = int'(eff[k-1]);
    got_q.delete();
    sent_q.delete();
    @(posedge iClk); #1;
    iStart = 1'b1;
    iSeed  = seed;
    iLen   = 12'(len);
    iPad   = 9'(pad);
    iValid = 1'b1;
    iData  = 1'($urandom);
    @(posedge iClk); #1;
    iStart = 1'b0;
    iValid = 1'b0;
    check("busy_after_start", int'(oBusy), 1);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        iValid = 1'b0;
        @(posedge iClk); #1;
      end
      if (dmode == 1 || i < 7) d = 1'b0;
      else if (dmode == 2) d = fixed_d[i];
      else d = 1'($urandom);
      iValid = 1'b1;
      iData  = d;
      if (mid_start && i == 5) begin
        iStart = 1'b1;
        iSeed  = 7'h11;
        iLen   = 12'd7;
        iPad   = 9'd9;
      end
      if (i == abort_at) begin
        iRst = 1'b1;
        @(posedge iClk); #1;
        iRst   = 1'b0;
        iValid = 1'b0;
        check("abort_outputs", int'({oValid, oData, oBusy, oDone}), 0);
        break;
      end
      fb = s[7] ^ s[4];
      o  = d ^ fb[0];
      if (tz && i >= 16 + 8 * len && i < 22 + 8 * len) o = 1'b0;
      for (int k = 7; k >= 2; k--) s[k] = s[k-1];
      s[1] = fb;
      sbq.push_back('{d: o, done: (i == n - 1), cyc: cyc + 1});
      sent_q.push_back(d);
      @(posedge iClk); #1;
      iStart = 1'b0;
    end
    iValid = 1'b0;
    for (int w = 0; w < 10 && sbq.size() != 0; w++) @(posedge iClk);
    #1;
    check("queue_drained", sbq.size(), 0);
    check("busy_after_frame", int'(oBusy), 0);
    if (abort_at < 0) check("out_count", got_q.size(), n);
  endtask

  // Additive descrambler seeded from the first 7 scrambled zero bits.
  task automatic loopback(input int len);
    int s[1:7];
    int fb;
    int bad;
    int n;
    bad = 0;
    n = got_q.size();
    for (int k = 1; k <= 7; k++) s[k] = int'(got_q[7-k]);
    for (int i = 7; i < n; i++) begin
      fb = s[7] ^ s[4];
      for (int k = 7; k >= 2; k--) s[k] = s[k-1];
      s[1] = fb;
      if (!(tz && i >= 16 + 8 * len && i < 22 + 8 * len) && i <= n - 7)
        if ((got_q[i] ^ fb[0]) != sent_q[i]) bad++;
    end
    check("loopback_errors", bad, 0);
  endtask

  initial begin
    bit [15:0] ref16;
    bit [4:0]  ref5;
    int        zc;
    int        diff;
`ifdef TX_SCR_TAIL_ZERO_EN
    tz = 1'b1;
`endif
    iRst = 1'b1; iStart = 1'b0; iSeed = '0; iLen = '0; iPad = '0;
    iValid = 1'b0; iData = 1'b0;
    repeat (3) @(posedge iClk);
    #1;
    check("reset_outputs", int'({oValid, oData, oBusy, oDone}), 0);
    iRst = 1'b0;

    // Known keystream for all-ones seed, zero data
    run_frame(7'h7f, 0, 0, 1, 1'b0, -1, 1'b0);
    ref16 = 16'b0000111011110010;
    ref5  = 5'b11001;
    diff = 0;
    for (int i = 0; i < 16; i++) if (got_q[i] != ref16[15-i]) diff++;
    check("known_first16", diff, 0);
    if (tz) begin
      zc = 0;
      for (int i = 16; i < 22; i++) if (got_q[i]) zc++;
      check("tail_zero", zc, 0);
    end else begin
      diff = 0;
      for (int i = 0; i < 5; i++) if (got_q[16+i] != ref5[4-i]) diff++;
      check("known_tail5", diff, 0);
    end

    // Seed 0 must match seed 1011101
    fixed_d.delete();
    for (int i = 0; i < 60; i++) fixed_d.push_back(1'($urandom));
    run_frame(7'h00, 3, 2, 2, 1'b0, -1, 1'b0);
    out_a = got_q;
    run_frame(7'b1011101, 3, 2, 2, 1'b0, -1, 1'b0);
    diff = 0;
    for (int i = 0; i < got_q.size(); i++) if (out_a[i] != got_q[i]) diff++;
    check("seed0_equiv", diff, 0);

    // L=2 P=3 with toggling valid: 41 outputs
    run_frame(7'(1 + $urandom_range(0, 126)), 2, 3, 0, 1'b1, -1, 1'b0);
    check("len2_pad3_count", got_q.size(), 41);
    loopback(2);

    // Mid-frame start ignored, then reset abort at bit 10
    run_frame(7'h2a, 1, 4, 0, 1'b0, 10, 1'b1);
    repeat (4) @(posedge iClk);
    #1;
    check("idle_after_abort", int'({oValid, oBusy, oDone}), 0);
    run_frame(7'h2a, 1, 4, 0, 1'b0, -1, 1'b1);
    loopback(1);

    for (int f = 0; f < 6; f++) begin
      int l;
      int p;
      l = $urandom_range(0, 4);
      p = $urandom_range(0, 9);
      run_frame(7'($urandom), l, p, 0, 1'($urandom), -1, 1'b0);
      loopback(l);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
